// File: rtl/core_pkg.sv
// Shared opcode classes, ACCU sub-ops, opcode field layout and FSM states
// for the shader core and its iterative square-root unit.
package core_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ALU2 = 2'b01;
  localparam logic [1:0] OP_ACCU = 2'b10;
  localparam logic [1:0] OP_MISC = 2'b11;

  localparam logic [1:0] AC_SHL  = 2'b00;
  localparam logic [1:0] AC_LSR  = 2'b01;
  localparam logic [1:0] AC_ASR  = 2'b10;
  localparam logic [1:0] AC_SQRT = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SQRT = 1'b1;

  // ra doubles as LOAD/MISC destination and carries the ACCU sub-op;
  // {rb[3:0],fl} is the LOAD immediate, rb[4]/rb[3] are MISC write/clear.
  typedef struct packed {
    logic [1:0] cls;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [3:0] fl;
  } op_t;

endpackage

// File: rtl/core_pipelined_sqrt_iter.sv
// Restoring integer square root, one result bit per cycle over BIT_WIDTH
// cycles; o_root carries the final root combinationally while o_done=1.
module sqrt_iter
  import core_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [2*BIT_WIDTH-1:0] i_radicand,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [BIT_WIDTH-1:0]   o_root
);

  localparam int W  = BIT_WIDTH;
  localparam int W2 = 2 * W;
  localparam int RW = W + 2;
  localparam int CW = $clog2(W + 1);

  logic [W2-1:0] r_rad;
  logic [RW-1:0] r_rem;
  logic [W-1:0]  r_root;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [RW+1:0] w_rem_sh;
  logic [RW+1:0] w_trial;
  logic          w_ge;
  logic [RW-1:0] w_rem_nx;
  logic [W-1:0]  w_root_nx;

  assign w_rem_sh  = {r_rem, r_rad[W2-1:W2-2]};
  assign w_trial   = {2'b00, r_root, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_rem_nx  = w_ge ? RW'(w_rem_sh - w_trial)
                          : RW'(w_rem_sh);
  assign w_root_nx = {r_root[W-2:0], w_ge};

  assign o_busy = r_busy;
  assign o_done = r_busy & (r_cnt == CW'(1));
  assign o_root = w_root_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rad  <= i_radicand;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= CW'(W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rad  <= {r_rad[W2-3:0], 2'b00};
      r_rem  <= w_rem_nx;
      r_root <= w_root_nx;
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1))
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/core_pipelined.sv
// Shader core: register file, 2*BIT_WIDTH accumulator ALU and iterative sqrt.
// Define CORE_SAT_EN for saturating add/sub/shl with a sticky sat_flag.
module core_pipelined
  import core_pkg::*;
#(
  parameter int CORE_ID        = 0,
  parameter int BIT_WIDTH      = 8,
  parameter int NR_LOCAL_REGS  = 8,
  parameter int NR_GLOBAL_REGS = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [15:0]                         opcode,
  input  logic                                exec_valid,
  output logic                                exec_ready,
  input  logic [NR_GLOBAL_REGS*BIT_WIDTH-1:0] global_regs,
  output logic [2*BIT_WIDTH-1:0]              accu,
  output logic                                busy,
  output logic                                done,
  output logic                                sat_flag
);

  localparam int W  = BIT_WIDTH;
  localparam int W2 = 2 * W;
  localparam logic [W-1:0] CID = W'(CORE_ID);

  op_t w_op;
  assign w_op = op_t'(opcode);

  logic [W-1:0]  r_loc [NR_LOCAL_REGS];
  logic [W2-1:0] r_accu;
  logic [0:0]    r_state;
  logic          r_done;

  logic          w_acc;
  logic          w_sq_go;
  logic          w_single;
  logic          w_sq_busy;
  logic          w_sq_done;
  logic [W-1:0]  w_root;

  logic [W-1:0]  w_ra;
  logic [W-1:0]  w_rb;
  logic [W-1:0]  w_imm;
  logic [W2-1:0] w_a;
  logic [W2-1:0] w_b;
  logic [W2-1:0] w_prod;
  logic [W2-1:0] w_add;
  logic [W2-1:0] w_sub;
  logic [W2-1:0] w_shl;
  logic [W2-1:0] w_lsr;
  logic [W2-1:0] w_asr;

  logic          w_accu_we;
  logic [W2-1:0] w_accu_nx;
  logic          w_wr_en;
  logic [W-1:0]  w_wr_dat;
  logic          w_clr;

  // 0..NR_LOCAL_REGS-1 local, 15 core id, 16.. global, all else zero
  function automatic logic [W-1:0] rd(input logic [4:0] idx);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NR_LOCAL_REGS; i++)
      if (idx == 5'(i)) v = r_loc[i];
    if (idx == 5'd15) v = CID;
    for (int g = 0; g < NR_GLOBAL_REGS; g++)
      if (idx == 5'(16 + g)) v = global_regs[g*W +: W];
    return v;
  endfunction

  assign w_ra   = rd(w_op.ra);
  assign w_rb   = rd(w_op.rb);
  assign w_imm  = W'({8'h00, w_op.rb[3:0], w_op.fl});
  assign w_a    = w_op.fl[2] ? r_accu : {{W{w_ra[W-1]}}, w_ra};
  assign w_b    = w_op.fl[3] ? r_accu : {{W{w_rb[W-1]}}, w_rb};
  assign w_prod = {{W{1'b0}}, w_ra} * {{W{1'b0}}, w_rb};
  assign w_lsr  = {1'b0, r_accu[W2-1:1]};
  assign w_asr  = {r_accu[W2-1], r_accu[W2-1:1]};

  assign w_acc    = exec_valid & (r_state == ST_IDLE);
  assign w_sq_go  = w_acc & (w_op.cls == OP_ACCU)
                  & (w_op.ra[4:3] == AC_SQRT);
  assign w_single = w_acc & ~w_sq_go;

`ifdef CORE_SAT_EN
  localparam logic [W2-1:0] SMAX = {1'b0, {(W2-1){1'b1}}};
  localparam logic [W2-1:0] SMIN = {1'b1, {(W2-1){1'b0}}};

  logic [W2:0] w_sum_x;
  logic [W2:0] w_dif_x;
  logic        w_add_ov;
  logic        w_sub_ov;
  logic        w_shl_ov;
  logic        w_ovf;
  logic        r_sat;

  assign w_sum_x  = {w_a[W2-1], w_a} + {w_b[W2-1], w_b};
  assign w_dif_x  = {w_a[W2-1], w_a} - {w_b[W2-1], w_b};
  assign w_add_ov = w_sum_x[W2] ^ w_sum_x[W2-1];
  assign w_sub_ov = w_dif_x[W2] ^ w_dif_x[W2-1];
  assign w_shl_ov = r_accu[W2-1] ^ r_accu[W2-2];

  assign w_add = w_add_ov ? (w_sum_x[W2] ? SMIN : SMAX)
                          : w_sum_x[W2-1:0];
  assign w_sub = w_sub_ov ? (w_dif_x[W2] ? SMIN : SMAX)
                          : w_dif_x[W2-1:0];
  assign w_shl = w_shl_ov ? (r_accu[W2-1] ? SMIN : SMAX)
                          : {r_accu[W2-2:0], 1'b0};

  always_comb begin
    w_ovf = 1'b0;
    if (w_op.cls == OP_ALU2 && !w_op.fl[1])
      w_ovf = w_op.fl[0] ? w_sub_ov : w_add_ov;
    else if (w_op.cls == OP_ACCU && w_op.ra[4:3] == AC_SHL)
      w_ovf = w_shl_ov;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_sat <= 1'b0;
    else if (w_single && w_clr)
      r_sat <= 1'b0;
    else if (w_single && w_ovf)
      r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`else
  assign w_add    = w_a + w_b;
  assign w_sub    = w_a - w_b;
  assign w_shl    = {r_accu[W2-2:0], 1'b0};
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    w_accu_we = 1'b0;
    w_accu_nx = r_accu;
    w_wr_en   = 1'b0;
    w_wr_dat  = w_imm;
    w_clr     = 1'b0;
    unique case (w_op.cls)
      OP_LOAD: w_wr_en = 1'b1;
      OP_ALU2: begin
        w_accu_we = 1'b1;
        if (w_op.fl[1])      w_accu_nx = w_prod;
        else if (w_op.fl[0]) w_accu_nx = w_sub;
        else                 w_accu_nx = w_add;
      end
      OP_ACCU: begin
        unique case (w_op.ra[4:3])
          AC_SHL: begin w_accu_we = 1'b1; w_accu_nx = w_shl; end
          AC_LSR: begin w_accu_we = 1'b1; w_accu_nx = w_lsr; end
          AC_ASR: begin w_accu_we = 1'b1; w_accu_nx = w_asr; end
          default: w_accu_we = 1'b0;
        endcase
      end
      default: begin
        w_wr_en  = w_op.rb[4];
        w_wr_dat = r_accu[W-1:0];
        if (w_op.rb[3]) begin
          w_accu_we = 1'b1;
          w_accu_nx = '0;
          w_clr     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_accu  <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < NR_LOCAL_REGS; i++)
        r_loc[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_single) begin
        r_done <= 1'b1;
        if (w_accu_we)
          r_accu <= w_accu_nx;
      end
      for (int i = 0; i < NR_LOCAL_REGS; i++)
        if (w_single && w_wr_en && w_op.ra == 5'(i))
          r_loc[i] <= w_wr_dat;
      if (w_sq_go)
        r_state <= ST_SQRT;
      if (r_state == ST_SQRT && w_sq_busy && w_sq_done) begin
        r_accu  <= {{W{1'b0}}, w_root};
        r_done  <= 1'b1;
        r_state <= ST_IDLE;
      end
    end
  end

  sqrt_iter #(
    .BIT_WIDTH (W)
  ) u_sqrt (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_sq_go),
    .i_radicand (r_accu),
    .o_busy     (w_sq_busy),
    .o_done     (w_sq_done),
    .o_root     (w_root)
  );

  assign accu       = r_accu;
  assign busy       = (r_state == ST_SQRT);
  assign exec_ready = (r_state == ST_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_core_pipelined.sv
// Self-checking bench for core_pipelined: directed scenarios plus random
// opcodes checked against an arithmetic reference model.
module tb_core_pipelined;

  localparam int BW  = 8;
  localparam int NL  = 8;
  localparam int NG  = 16;
  localparam int CID = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [15:0]    opcode;
  logic           exec_valid;
  logic           exec_ready;
  logic [NG*BW-1:0] global_regs;
  logic [2*BW-1:0]  accu;
  logic           busy;
  logic           done;
  logic           sat_flag;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned m_accu;
  int          m_loc [NL];
  int          m_glob [NG];
  bit          m_sat;

  always #5 clk = ~clk;

  core_pipelined #(
    .CORE_ID        (CID),
    .BIT_WIDTH      (BW),
    .NR_LOCAL_REGS  (NL),
    .NR_GLOBAL_REGS (NG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .exec_valid  (exec_valid),
    .exec_ready  (exec_ready),
    .global_regs (global_regs),
    .accu        (accu),
    .busy        (busy),
    .done        (done),
    .sat_flag    (sat_flag)
  );

  function automatic logic [15:0] f_load(int d, int imm);
    return {2'b00, 5'(d), 1'b0, 8'(imm)};
  endfunction

  function automatic logic [15:0] f_alu(int a, int b, logic [3:0] fl);
    return {2'b01, 5'(a), 5'(b), fl};
  endfunction

  function automatic logic [15:0] f_misc(int d, bit wr, bit clr);
    return {2'b11, 5'(d), wr, clr, 7'h00};
  endfunction

  localparam logic [15:0] OPC_SHL  = 16'h8000;
  localparam logic [15:0] OPC_LSR  = 16'h9000;
  localparam logic [15:0] OPC_ASR  = 16'hA000;
  localparam logic [15:0] OPC_SQRT = 16'hB000;

  function automatic int sx8(int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int sx16(int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic int m_rd(int idx);
    if (idx < NL) return m_loc[idx];
    if (idx == 15) return CID;
    if (idx >= 16 && idx < 16 + NG) return m_glob[idx-16];
    return 0;
  endfunction

  function automatic int unsigned m_fit(int v);
`ifdef CORE_SAT_EN
    if (v > 32767) begin m_sat = 1'b1; return 32'h7FFF; end
    if (v < -32768) begin m_sat = 1'b1; return 32'h8000; end
`endif
    return v & 32'hFFFF;
  endfunction

  function automatic void m_exec(input logic [15:0] op);
    int d, ra, rb, a, b, r;
    d = int'(op[13:9]);
    case (op[15:14])
      2'b00: if (d < NL) m_loc[d] = int'(op[7:0]);
      2'b01: begin
        ra = m_rd(d);
        rb = m_rd(int'(op[8:4]));
        a  = op[2] ? sx16(m_accu) : sx8(ra);
        b  = op[3] ? sx16(m_accu) : sx8(rb);
        if (op[1])      m_accu = ra * rb;
        else if (op[0]) m_accu = m_fit(a - b);
        else            m_accu = m_fit(a + b);
      end
      2'b10: begin
        case (op[13:12])
          2'b00: m_accu = m_fit(sx16(m_accu) * 2);
          2'b01: m_accu = m_accu / 2;
          2'b10: begin
            r = sx16(m_accu);
            m_accu = (r >>> 1) & 32'hFFFF;
          end
          default: begin
            r = 0;
            while ((r + 1) * (r + 1) <= int'(m_accu)) r++;
            m_accu = r;
          end
        endcase
      end
      default: begin
        if (op[8] && d < NL) m_loc[d] = m_accu & 32'hFF;
        if (op[7]) begin m_accu = 0; m_sat = 1'b0; end
      end
    endcase
  endfunction

  task automatic set_globals();
    for (int g = 0; g < NG; g++)
      global_regs[g*BW +: BW] = 8'(m_glob[g]);
  endtask

  task automatic m_reset();
    m_accu = 0;
    m_sat  = 1'b0;
    for (int i = 0; i < NL; i++) m_loc[i] = 0;
  endtask

  task automatic exec_op(input logic [15:0] op);
    opcode     = op;
    exec_valid = 1'b1;
    @(posedge clk); #1;
    exec_valid = 1'b0;
    m_exec(op);
  endtask

  task automatic run_sqrt(input logic [15:0] junk);
    logic [15:0] old;
    old        = m_accu[15:0];
    opcode     = OPC_SQRT;
    exec_valid = 1'b1;
    @(posedge clk); #1;
    opcode = junk;
    for (int k = 0; k < BW; k++) begin
      n_tests++;
      if (busy !== 1'b1 || exec_ready !== 1'b0 ||
          done !== 1'b0 || accu !== old) begin
        n_fail++;
        $display("FAIL sqrt_busy c%0d: b/r/d=%b%b%b accu=%h want 100 %h",
                 k, busy, exec_ready, done, accu, old);
      end
      @(posedge clk); #1;
    end
    exec_valid = 1'b0;
    m_exec(OPC_SQRT);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || exec_ready !== 1'b1 ||
        accu !== m_accu[15:0]) begin
      n_fail++;
      $display("FAIL sqrt_end: d/b/r=%b%b%b accu=%h want 101 %h",
               done, busy, exec_ready, accu, m_accu[15:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exec_valid = 1'b0;
    opcode = 16'h0000;
    for (int g = 0; g < NG; g++) m_glob[g] = 0;
    set_globals();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (accu !== 16'h0000 || exec_ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: accu=%h r/b/d/s=%b%b%b%b want 0000 1000",
               accu, exec_ready, busy, done, sat_flag);
    end
  endtask

  task automatic test_load_add();
    logic [15:0] ops [3];
    ops[0] = f_load(0, 'h7F);
    ops[1] = f_load(1, 'h81);
    ops[2] = f_alu(0, 1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      exec_op(ops[i]);
      n_tests++;
      if (done !== 1'b1 || exec_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_done op%0d: done=%b ready=%b want 1 1",
                 i, done, exec_ready);
      end
    end
    n_tests++;
    if (accu !== 16'h0000) begin
      n_fail++;
      $display("FAIL add_7f_81: accu=%h want 0000", accu);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_idle: done=%b want 0", done);
    end
  endtask

  task automatic test_mul_sqrt();
    exec_op(f_load(2, 'h10));
    exec_op(f_alu(2, 2, 4'b0010));
    n_tests++;
    if (accu !== 16'h0100) begin
      n_fail++;
      $display("FAIL mul_10_10: accu=%h want 0100", accu);
    end
    run_sqrt(f_misc(0, 1'b0, 1'b1));
    n_tests++;
    if (accu !== 16'h0010) begin
      n_fail++;
      $display("FAIL sqrt_100: accu=%h want 0010", accu);
    end
  endtask

  task automatic test_sqrt_edges();
    exec_op(f_load(3, 'hFF));
    exec_op(f_alu(3, 14, 4'b0000));
    n_tests++;
    if (accu !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sext_ff: accu=%h want ffff", accu);
    end
    run_sqrt(f_load(0, 'h55));
    n_tests++;
    if (accu !== 16'h00FF) begin
      n_fail++;
      $display("FAIL sqrt_ffff: accu=%h want 00ff", accu);
    end
    exec_op(f_misc(0, 1'b0, 1'b1));
    run_sqrt(f_alu(0, 0, 4'b0000));
    n_tests++;
    if (accu !== 16'h0000) begin
      n_fail++;
      $display("FAIL sqrt_0: accu=%h want 0000", accu);
    end
    exec_op(f_alu(0, 14, 4'b0000));
    n_tests++;
    if (accu !== 16'h007F) begin
      n_fail++;
      $display("FAIL held_op_ignored: accu=%h want 007f", accu);
    end
  endtask

  task automatic test_regmap();
    exec_op(f_alu(15, 14, 4'b0000));
    n_tests++;
    if (accu !== 16'h0003) begin
      n_fail++;
      $display("FAIL core_id: accu=%h want 0003", accu);
    end
    m_glob[0] = 'hF0;
    set_globals();
    exec_op(f_alu(16, 14, 4'b0000));
    n_tests++;
    if (accu !== 16'hFFF0) begin
      n_fail++;
      $display("FAIL global16: accu=%h want fff0", accu);
    end
    exec_op(f_load(8, 'h55));
    exec_op(f_alu(8, 14, 4'b0000));
    n_tests++;
    if (accu !== 16'h0000) begin
      n_fail++;
      $display("FAIL reg8_zero: accu=%h want 0000", accu);
    end
  endtask

  task automatic make_8001();
    exec_op(f_load(4, 'h80));
    exec_op(f_load(5, 'h01));
    exec_op(f_alu(4, 4, 4'b0010));
    exec_op(f_alu(14, 0, 4'b1001));
    exec_op(f_alu(0, 0, 4'b1100));
    exec_op(f_alu(0, 5, 4'b0100));
  endtask

  task automatic test_shifts();
    make_8001();
    n_tests++;
    if (accu !== 16'h8001) begin
      n_fail++;
      $display("FAIL build_8001: accu=%h want 8001", accu);
    end
    exec_op(OPC_ASR);
    n_tests++;
    if (accu !== 16'hC000) begin
      n_fail++;
      $display("FAIL asr_8001: accu=%h want c000", accu);
    end
    make_8001();
    exec_op(OPC_LSR);
    n_tests++;
    if (accu !== 16'h4000) begin
      n_fail++;
      $display("FAIL lsr_8001: accu=%h want 4000", accu);
    end
    exec_op(OPC_SHL);
    n_tests++;
    if (accu !== m_accu[15:0]) begin
      n_fail++;
      $display("FAIL shl_4000: accu=%h want %h", accu, m_accu[15:0]);
    end
  endtask

  task automatic test_sat();
    logic [15:0] e_accu;
    logic        e_sat;
`ifdef CORE_SAT_EN
    e_accu = 16'h7FFF;
    e_sat  = 1'b1;
`else
    e_accu = 16'h8002;
    e_sat  = 1'b0;
`endif
    exec_op(f_misc(0, 1'b0, 1'b1));
    exec_op(f_load(6, 'hD9));
    exec_op(f_load(7, 'h97));
    exec_op(f_alu(6, 7, 4'b0010));
    n_tests++;
    if (accu !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL mul_7fff: accu=%h want 7fff", accu);
    end
    exec_op(f_alu(0, 15, 4'b0100));
    n_tests++;
    if (accu !== e_accu || sat_flag !== e_sat) begin
      n_fail++;
      $display("FAIL sat_add: accu=%h sat=%b want %h %b",
               accu, sat_flag, e_accu, e_sat);
    end
    exec_op(f_alu(15, 14, 4'b0000));
    n_tests++;
    if (sat_flag !== e_sat) begin
      n_fail++;
      $display("FAIL sat_sticky: sat=%b want %b", sat_flag, e_sat);
    end
    exec_op(f_misc(1, 1'b1, 1'b1));
    n_tests++;
    if (accu !== 16'h0000 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: accu=%h sat=%b want 0000 0",
               accu, sat_flag);
    end
    exec_op(f_alu(1, 14, 4'b0000));
    n_tests++;
    if (accu !== 16'h0003) begin
      n_fail++;
      $display("FAIL misc_wr: accu=%h want 0003", accu);
    end
  endtask

  task automatic test_random();
    logic [15:0] op;
    for (int g = 0; g < NG; g++) m_glob[g] = $urandom_range(0, 255);
    set_globals();
    for (int n = 0; n < 300; n++) begin
      op = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        n_tests++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_gap %0d: done=%b want 0", n, done);
        end
      end else if (op[15:12] == 4'hB) begin
        run_sqrt(16'($urandom));
      end else begin
        exec_op(op);
        n_tests++;
        if (accu !== m_accu[15:0] || sat_flag !== m_sat ||
            done !== 1'b1 || exec_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd %0d op=%h: accu=%h s/d/r=%b%b%b want %h %b11",
                   n, op, accu, sat_flag, done, exec_ready,
                   m_accu[15:0], m_sat);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sqrt();
    exec_op(f_load(2, 'h40));
    exec_op(f_alu(2, 2, 4'b0010));
    opcode     = OPC_SQRT;
    exec_valid = 1'b1;
    @(posedge clk); #1;
    exec_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    m_reset();
    n_tests++;
    if (accu !== 16'h0000 || busy !== 1'b0 || exec_ready !== 1'b1 ||
        done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_sqrt: accu=%h b/r/d=%b%b%b want 0000 010",
               accu, busy, exec_ready, done);
    end
    rst = 1'b0;
    repeat (BW + 2) begin
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || accu !== 16'h0000) begin
        n_fail++;
        $display("FAIL rst_no_done: done=%b accu=%h want 0 0000",
                 done, accu);
      end
    end
    exec_op(f_alu(0, 15, 4'b0000));
    n_tests++;
    if (accu !== 16'h0003) begin
      n_fail++;
      $display("FAIL rst_locals: accu=%h want 0003", accu);
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_mul_sqrt();
    test_sqrt_edges();
    test_regmap();
    test_shifts();
    test_sat();
    test_random();
    test_reset_mid_sqrt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
